// File: rtl/axis_pkg.sv
// axis_pkg: default widths, reference beat layout and release-state encoding for axis_pkt_fifo
// Widths here are defaults only; axis_pkt_fifo re-derives its beat layout from its own parameters.
package axis_pkg;
  localparam int AXIS_DATA_W = 32;
  localparam int AXIS_USER_W = 1;
  localparam int AXIS_ID_W = 1;
  localparam int AXIS_DEST_W = 1;
  localparam int AXIS_DEPTH = 16;
  typedef struct packed {
    logic [AXIS_DATA_W-1:0]   tdata;
    logic [AXIS_DATA_W/8-1:0] tstrb;
    logic [AXIS_DATA_W/8-1:0] tkeep;
    logic                     tlast;
    logic [AXIS_ID_W-1:0]     tid;
    logic [AXIS_DEST_W-1:0]   tdest;
    logic [AXIS_USER_W-1:0]   tuser;
  } axis_beat_t;
  typedef enum logic {REL_IDLE, REL_ACTIVE} rel_state_t;
endpackage

// File: rtl/axis_fifo_mem.sv
// axis_fifo_mem: DEPTH x W register array, one write port, asynchronous head read port
// Ports: ACLK/ARESET clock and async reset; we/waddr/wdata write port; raddr/rdata head read.
// Entries clear on reset so the head reads as zero rather than X while the FIFO is empty.
module axis_fifo_mem #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          ACLK,
  input  logic          ARESET,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) mem <= '{default: '0};
    else if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: AXI-Stream FIFO with full sideband, cut-through or store-and-forward with oversize release
// Ports: ACLK/ARESET clock and async reset; s_* upstream slave side; m_* downstream master side;
// fill = stored beats, pkt_cnt = stored complete frames, releasing = oversize-frame release active.
module axis_pkt_fifo
  import axis_pkg::*;
#(
  parameter int DATA_W = AXIS_DATA_W,
  parameter int USER_W = AXIS_USER_W,
  parameter int ID_WIDTH = AXIS_ID_W,
  parameter int DEST_WIDTH = AXIS_DEST_W,
  parameter int DEPTH = AXIS_DEPTH,
  parameter int PKT_MODE = 0,
  localparam int KEEP_STRB_W = DATA_W / 8,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic [DATA_W-1:0]      s_tdata,
  input  logic [KEEP_STRB_W-1:0] s_tstrb,
  input  logic [KEEP_STRB_W-1:0] s_tkeep,
  input  logic                   s_tlast,
  input  logic [ID_WIDTH-1:0]    s_tid,
  input  logic [DEST_WIDTH-1:0]  s_tdest,
  input  logic [USER_W-1:0]      s_tuser,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [DATA_W-1:0]      m_tdata,
  output logic [KEEP_STRB_W-1:0] m_tstrb,
  output logic [KEEP_STRB_W-1:0] m_tkeep,
  output logic                   m_tlast,
  output logic [ID_WIDTH-1:0]    m_tid,
  output logic [DEST_WIDTH-1:0]  m_tdest,
  output logic [USER_W-1:0]      m_tuser,
  output logic [CW-1:0]          fill,
  output logic [CW-1:0]          pkt_cnt,
  output logic                   releasing
);
  localparam int AW = $clog2(DEPTH);
  typedef struct packed {
    logic [DATA_W-1:0]      tdata;
    logic [KEEP_STRB_W-1:0] tstrb;
    logic [KEEP_STRB_W-1:0] tkeep;
    logic                   tlast;
    logic [ID_WIDTH-1:0]    tid;
    logic [DEST_WIDTH-1:0]  tdest;
    logic [USER_W-1:0]      tuser;
  } beat_t;
  beat_t wr_beat, head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fill_next, pkt_cnt_next;
  logic wr, rd;
  rel_state_t rel_state;
  assign wr = s_tvalid && s_tready;
  assign rd = m_tvalid && m_tready;
  // store-and-forward holds the head back until a whole frame is stored, unless releasing an oversize frame
  assign m_tvalid = (fill != '0) && (PKT_MODE == 0 || pkt_cnt != '0 || releasing);
  assign fill_next = fill + CW'(wr) - CW'(rd);
  assign pkt_cnt_next = pkt_cnt + CW'(wr && s_tlast) - CW'(rd && head.tlast);
  assign wr_beat = '{tdata: s_tdata, tstrb: s_tstrb, tkeep: s_tkeep, tlast: s_tlast,
                     tid: s_tid, tdest: s_tdest, tuser: s_tuser};
  assign {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser} = head;
  axis_fifo_mem #(.W($bits(beat_t)), .DEPTH(DEPTH)) u_mem (
    .ACLK(ACLK),
    .ARESET(ARESET),
    .we(wr),
    .waddr(wr_ptr),
    .wdata(wr_beat),
    .raddr(rd_ptr),
    .rdata(head)
  );
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill <= '0;
      pkt_cnt <= '0;
      s_tready <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr);
      rd_ptr <= rd_ptr + AW'(rd);
      fill <= fill_next;
      pkt_cnt <= pkt_cnt_next;
      s_tready <= fill_next < CW'(DEPTH);
    end
  // a full buffer with no complete frame can only drain by releasing the frame it holds
  always_ff @(posedge ACLK or posedge ARESET)
    if (ARESET) begin
      rel_state <= REL_IDLE;
      releasing <= 1'b0;
    end else if (PKT_MODE != 0) begin
      if (rel_state == REL_IDLE && fill == CW'(DEPTH) && pkt_cnt == '0) begin
        rel_state <= REL_ACTIVE;
        releasing <= 1'b1;
      end else if (rel_state == REL_ACTIVE && rd && head.tlast) begin
        rel_state <= REL_IDLE;
        releasing <= 1'b0;
      end
    end
endmodule

// File: tb/tb_axis_pkt_fifo.sv
// tb_axis_pkt_fifo: cut-through and packet-mode instances checked against a queue model every cycle
module tb_axis_pkt_fifo;
  typedef logic [43:0] bt;
  logic ACLK = 1'b0, ARESET = 1'b1;
  always #5 ACLK = ~ACLK;
  int n_cmp = 0, n_err = 0;
  bt src0[$], src1[$];
  logic sv0 = 1'b0, sv1 = 1'b0, mr0 = 1'b0, mr1 = 1'b0, gap = 1'b0, rnd = 1'b0;
  bt sb0 = '0, sb1 = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gd
    logic sv, mr, sr, mv, rel, acc = 1'b0, e_sr = 1'b0, e_rel = 1'b0;
    bt sb, mb;
    bt q[$];
    logic [2:0] fl, pc;
    assign sv = (g == 1) ? sv1 : sv0;
    assign sb = (g == 1) ? sb1 : sb0;
    assign mr = (g == 1) ? mr1 : mr0;
    axis_pkt_fifo #(.DEPTH(4), .PKT_MODE(g)) u_dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .s_tvalid(sv), .s_tready(sr), .s_tdata(sb[43:12]), .s_tstrb(sb[11:8]), .s_tkeep(sb[7:4]),
      .s_tlast(sb[3]), .s_tid(sb[2]), .s_tdest(sb[1]), .s_tuser(sb[0]),
      .m_tvalid(mv), .m_tready(mr), .m_tdata(mb[43:12]), .m_tstrb(mb[11:8]), .m_tkeep(mb[7:4]),
      .m_tlast(mb[3]), .m_tid(mb[2]), .m_tdest(mb[1]), .m_tuser(mb[0]),
      .fill(fl), .pkt_cnt(pc), .releasing(rel)
    );
    function automatic int nlast();
      int n = 0;
      foreach (q[i]) n += int'(q[i][3]);
      return n;
    endfunction
    function automatic logic e_mv();
      return q.size() != 0 && (g == 0 || nlast() != 0 || e_rel);
    endfunction
    initial forever begin
      @(posedge ACLK or posedge ARESET);
      if (ARESET) begin
        q.delete();
        e_sr = 1'b0;
        e_rel = 1'b0;
        acc = 1'b0;
      end else begin
        logic wr, rd, rdl;
        int sz0, nl0;
        wr = sv && e_sr;
        rd = e_mv() && mr;
        rdl = rd && q[0][3];
        sz0 = q.size();
        nl0 = nlast();
        if (rd) void'(q.pop_front());
        if (wr) q.push_back(sb);
        e_sr = q.size() < 4;
        if (g == 1) e_rel = e_rel ? !rdl : (sz0 == 4 && nl0 == 0);
        acc = wr;
      end
    end
    initial forever begin
      @(negedge ACLK);
      check($sformatf("d%0d s_tready", g), sr, e_sr);
      check($sformatf("d%0d m_tvalid", g), mv, e_mv());
      check($sformatf("d%0d fill", g), fl, q.size());
      check($sformatf("d%0d pkt_cnt", g), pc, nlast());
      check($sformatf("d%0d releasing", g), rel, e_rel);
      if (e_mv()) check($sformatf("d%0d head beat", g), mb, q[0]);
    end
  end

  initial forever begin
    @(posedge ACLK);
    #1;
    if (gd[0].acc && src0.size() != 0) void'(src0.pop_front());
    if (gd[1].acc && src1.size() != 0) void'(src1.pop_front());
    if (rnd) begin
      mr0 = $urandom_range(0, 3) != 0;
      mr1 = $urandom_range(0, 3) != 0;
      gap = $urandom_range(0, 3) == 0;
    end
    sv0 = src0.size() != 0 && (!gap || (sv0 && !gd[0].acc));
    sv1 = src1.size() != 0 && (!gap || (sv1 && !gd[1].acc));
    sb0 = src0.size() != 0 ? src0[0] : '0;
    sb1 = src1.size() != 0 ? src1[0] : '0;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge ACLK);
    #2;
  endtask

  function automatic bt mk(input logic last);
    bt b;
    b = {$urandom, 12'($urandom)};
    b[3] = last;
    return b;
  endfunction

  task automatic push_frame(input logic [1:0] which, input int len, input logic last_end);
    for (int i = 0; i < len; i++) begin
      bt b;
      b = mk(last_end && i == len - 1);
      if (which[0]) src0.push_back(b);
      if (which[1]) src1.push_back(b);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((src0.size() != 0 || src1.size() != 0 || gd[0].q.size() != 0 || gd[1].q.size() != 0
            || gd[0].fl != 0 || gd[1].fl != 0) && t < 500) begin
      cyc(1);
      t++;
    end
    check("drain within budget", t < 500, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    cyc(3);
    check("reset s_tready", {gd[1].sr, gd[0].sr}, 2'b00);
    check("reset m_tvalid", {gd[1].mv, gd[0].mv}, 2'b00);
    check("reset payload zero", gd[0].mb, 0);
    ARESET = 1'b0;
    cyc(1);
    check("s_tready after reset", {gd[1].sr, gd[0].sr}, 2'b11);
    // pass-through: cut-through never holds more than one beat
    mr0 = 1'b1;
    mr1 = 1'b1;
    push_frame(2'b11, 10, 1'b1);
    repeat (14) begin
      cyc(1);
      check("d0 fill<=1", gd[0].fl <= 1, 1);
    end
    wait_idle();
    // fill, backpressure, then 16 beats stream through a depth-4 buffer without bubbles
    mr0 = 1'b0;
    mr1 = 1'b0;
    push_frame(2'b11, 4, 1'b1);
    cyc(7);
    check("d0 full fill", gd[0].fl, 4);
    check("d0 full s_tready", gd[0].sr, 0);
    check("model full fill", gd[0].q.size(), 4);
    check("d1 full pkt_cnt", gd[1].pc, 1);
    check("d1 full m_tvalid", gd[1].mv, 1);
    push_frame(2'b11, 12, 1'b1);
    mr0 = 1'b1;
    mr1 = 1'b1;
    repeat (15) begin
      check("d0 no bubble", gd[0].mv, 1);
      cyc(1);
    end
    wait_idle();
    // store-and-forward: 2 beats, gap, then TLAST
    push_frame(2'b10, 2, 1'b0);
    cyc(4);
    check("d1 partial fill", gd[1].fl, 2);
    check("d1 partial m_tvalid", gd[1].mv, 0);
    check("d1 partial pkt_cnt", gd[1].pc, 0);
    push_frame(2'b10, 1, 1'b1);
    cyc(1);
    check("d1 before last m_tvalid", gd[1].mv, 0);
    cyc(1);
    check("d1 after last m_tvalid", gd[1].mv, 1);
    check("d1 after last pkt_cnt", gd[1].pc, 1);
    cyc(3);
    check("d1 drained pkt_cnt", gd[1].pc, 0);
    check("d1 drained fill", gd[1].fl, 0);
    // TLAST written and read on the same edge
    mr1 = 1'b0;
    push_frame(2'b10, 1, 1'b1);
    cyc(3);
    check("d1 one frame pkt_cnt", gd[1].pc, 1);
    push_frame(2'b10, 1, 1'b1);
    cyc(1);
    mr1 = 1'b1;
    cyc(1);
    check("d1 simult pkt_cnt", gd[1].pc, 1);
    check("d1 simult fill", gd[1].fl, 1);
    cyc(1);
    check("d1 simult drained", gd[1].pc, 0);
    wait_idle();
    // 7-beat frame through a 4-deep store-and-forward buffer
    mr1 = 1'b0;
    push_frame(2'b10, 7, 1'b1);
    cyc(5);
    check("d1 oversize fill", gd[1].fl, 4);
    check("d1 oversize pkt_cnt", gd[1].pc, 0);
    check("d1 oversize pre-release", gd[1].rel, 0);
    cyc(1);
    check("d1 releasing", gd[1].rel, 1);
    mr1 = 1'b1;
    wait_idle();
    check("d1 release ended", gd[1].rel, 0);
    // reset with a partial frame stored
    mr0 = 1'b0;
    mr1 = 1'b0;
    push_frame(2'b11, 3, 1'b0);
    cyc(6);
    check("pre-reset fill", {gd[1].fl, gd[0].fl}, {3'd3, 3'd3});
    #1;
    ARESET = 1'b1;
    #1;
    check("async reset m_tvalid", {gd[1].mv, gd[0].mv}, 2'b00);
    check("async reset fill", {gd[1].fl, gd[0].fl}, 6'd0);
    check("async reset pkt_cnt", {gd[1].pc, gd[0].pc}, 6'd0);
    src0.delete();
    src1.delete();
    cyc(2);
    ARESET = 1'b0;
    push_frame(2'b11, 3, 1'b1);
    mr0 = 1'b1;
    mr1 = 1'b1;
    wait_idle();
    // randomized traffic
    rnd = 1'b1;
    repeat (1500) begin
      cyc(1);
      if (src0.size() < 4 && $urandom_range(0, 3) == 0) push_frame(2'b01, $urandom_range(1, 9), 1'b1);
      if (src1.size() < 4 && $urandom_range(0, 3) == 0) push_frame(2'b10, $urandom_range(1, 9), 1'b1);
    end
    rnd = 1'b0;
    cyc(1);
    mr0 = 1'b1;
    mr1 = 1'b1;
    gap = 1'b0;
    wait_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
